gpu_vram_ctl: RTL and testbench
===============================

Name: gpu_vram_ctl

Overview:
Parametrised successor to the GPU character/framebuffer VRAM. It wraps a dual-port, byte-strobed RAM with three paths:
- a CPU port with a valid/ready handshake;
- a free-running video scan read port that takes byte addresses;
- a hardware fill engine that clears or fills a word range, one word per cycle.
It sits between the SoC bus decoder and the GPU scanout/character generator. Mono and text modes are selected by parameters, not ifdefs.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
DEPTH, 1536, number of words (1536 = 128x48 mono, 500 = 80x25 text)
ADDR_W, 11, CPU/fill word-address width; must satisfy 2^ADDR_W >= DEPTH
VID_ADDR_W, 13, video-port byte-address width
VID_SHIFT, 2, right shift from video byte address to word index; equals log2(DATA_W/8)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_valid  in  1  CPU request; held high until cpu_ready
cpu_ready  out  1  one-cycle acknowledge
cpu_addr  in  ADDR_W  word address
cpu_wstrb  in  DATA_W/8  byte write strobes; all zero means read
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
vid_addr  in  VID_ADDR_W  scanout byte address
vid_rdata  out  DATA_W  word at vid_addr>>VID_SHIFT, one cycle later
fill_start  in  1  start-fill pulse
fill_base  in  ADDR_W  first word to fill
fill_count  in  ADDR_W+1  number of words to fill
fill_data  in  DATA_W  fill pattern
fill_busy  out  1  fill engine active
fill_done  out  1  one-cycle pulse when a fill completes

Behaviour:
- Reset: cpu_ready=0, cpu_rdata=0, vid_rdata=0, fill_busy=0, fill_done=0, FSM=IDLE. RAM contents are not cleared.
- Reset mid-fill aborts the fill: the words already written stay written, and no fill_done pulse is issued.

CPU port:
- A request is accepted in cycle N when cpu_valid=1 and cpu_ready=0 and FSM is not FILL.
- In cycle N the write applies only the bytes whose strobe is set; a read samples the pre-write word.
- cpu_ready=1 in cycle N+1, with cpu_rdata holding that word. Write-only cycles also return the old word.
- No new accept is possible in the cycle where cpu_ready=1, so back-to-back transactions are spaced 2 cycles apart.
- cpu_addr >= DEPTH: the write is dropped, cpu_rdata=0, and the request is still acknowledged.

Video port:
- Always active, including during a fill. Latency is 1 cycle.
- Word index = vid_addr >> VID_SHIFT. An index >= DEPTH returns 0.
- During a fill, a read of the word being written in the same cycle returns the old value.

Fill FSM: IDLE -> FILL -> DONE -> IDLE.
- IDLE: when fill_start=1, latch base, count and data into registers, then move to FILL, or to DONE if fill_count=0.
- FILL: each cycle, write fill_data with all strobes set to ptr, then ptr+1 and rem-1.
  - Leave FILL when rem reaches 1, or when ptr+1 >= DEPTH (clip at the end of the array; no wrap).
  - fill_busy=1 throughout the FILL state.
- DONE: fill_done=1 for one cycle, then IDLE.
- fill_start while the FSM is not IDLE is ignored.
- A CPU request arriving during FILL stalls with cpu_ready=0 and is accepted in the first cycle after FILL ends (the DONE cycle).
- fill_start and cpu_valid in the same IDLE cycle: both are accepted. The CPU access completes in that cycle and the first fill write occurs the next cycle, so the fill overwrites it if the ranges overlap.
- Fill throughput: count words take count+1 cycles from fill_start to the fill_done pulse, plus 1 cycle.

Decomposition:
- Package gpu_pkg:
  - fill FSM state enum (IDLE, FILL, DONE);
  - localparams GPU_DEPTH_MONO=1536, GPU_DEPTH_TEXT=500;
  - default widths.
- Sub-module gpu_vram_bank (DATA_W, DEPTH): inferable RAM with one read/write port that has per-byte strobes and a registered read, plus one registered read-only port, no reset. This keeps BRAM inference isolated from the controller and FSM logic.

Test Plan:
- CPU write 0xDEADBEEF to addr 5, wstrb=0xF; then write 0x000000AA with wstrb=0x1; then read addr 5 -> cpu_rdata=0xDEADBEAA, cpu_ready exactly one cycle after each accept.
- After writing addr 7 = 0x12345678, drive vid_addr=28..31 -> vid_rdata=0x12345678 one cycle later. vid_addr=6144 with DEPTH=1536 -> 0.
- fill_start with base=10, count=4, data=0x20202020 -> fill_busy high for 4 cycles, fill_done pulses once, words 10..13 = 0x20202020, words 9 and 14 unchanged.
- CPU read of addr 12 issued one cycle after fill_start (count=4) -> cpu_ready held low until FILL ends, then returns 0x20202020.
- Fill with base=1534, count=8, DEPTH=1536 -> only words 1534 and 1535 are written, fill_done pulses, no wrap to word 0. Fill with count=0 -> fill_done only, no writes.
- Assert rst during a fill with count=100 after 10 writes -> fill_busy=0 and cpu_ready=0 next cycle, no fill_done, the first 10 words are filled and the remainder unchanged.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared fill-FSM state type, VRAM geometry presets and default widths.
package gpu_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;
  localparam int GPU_DEPTH_MONO = 1536;
  localparam int GPU_DEPTH_TEXT = 500;
  localparam int GPU_DATA_W = 32;
  localparam int GPU_ADDR_W = 11;
  localparam int GPU_VID_ADDR_W = 13;
  localparam int GPU_VID_SHIFT = 2;
endpackage

// File: rtl/gpu_vram_ctl_if.sv
// gpu_vram_ctl_if: CPU handshake, video scan and fill-engine signals of the VRAM controller.
interface gpu_vram_ctl_if import gpu_pkg::*; #(
  parameter int DATA_W = GPU_DATA_W,
  parameter int ADDR_W = GPU_ADDR_W,
  parameter int VID_ADDR_W = GPU_VID_ADDR_W
);
  logic cpu_valid, cpu_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W/8-1:0] cpu_wstrb;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic [VID_ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic fill_start, fill_busy, fill_done;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W:0] fill_count;
  logic [DATA_W-1:0] fill_data;
  modport master (
    output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, vid_addr, fill_start, fill_base, fill_count, fill_data,
    input cpu_ready, cpu_rdata, vid_rdata, fill_busy, fill_done
  );
  modport slave (
    input cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, vid_addr, fill_start, fill_base, fill_count, fill_data,
    output cpu_ready, cpu_rdata, vid_rdata, fill_busy, fill_done
  );
endinterface

// File: rtl/gpu_vram_bank.sv
// gpu_vram_bank: byte-strobed read/write port plus read-only port, both registered, no reset.
module gpu_vram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1536,
  parameter int AW = $clog2(DEPTH)
)(
  input  logic clk,
  input  logic [AW-1:0] a_addr,
  input  logic [DATA_W/8-1:0] a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_q,
  input  logic [AW-1:0] b_addr,
  output logic [DATA_W-1:0] b_q
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++)
      if (a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    a_q <= mem[a_addr];
  end
  always_ff @(posedge clk) b_q <= mem[b_addr];
endmodule

// File: rtl/gpu_vram_ctl.sv
// gpu_vram_ctl: VRAM controller arbitrating CPU accesses and a word-per-cycle fill engine
// on one RAM port, with a free-running video read on the other.
module gpu_vram_ctl import gpu_pkg::*; #(
  parameter int DATA_W = GPU_DATA_W,
  parameter int DEPTH = GPU_DEPTH_MONO,
  parameter int ADDR_W = GPU_ADDR_W,
  parameter int VID_ADDR_W = GPU_VID_ADDR_W,
  parameter int VID_SHIFT = GPU_VID_SHIFT
)(
  input logic clk,
  input logic rst,
  gpu_vram_ctl_if.slave bus
);
  localparam int NB = DATA_W/8;
  localparam int AW = $clog2(DEPTH);
  localparam int VI = VID_ADDR_W - VID_SHIFT;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [VI:0] VLIM = (VI+1)'(DEPTH);
  fill_state_t state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0] rem;
  logic [DATA_W-1:0] fdata, a_wdata, a_q, b_q;
  logic [AW-1:0] a_addr, b_addr;
  logic [NB-1:0] a_we;
  logic [VI-1:0] vid_idx;
  logic accept, cpu_ok, fill_ok, vid_ok, last, cpu_ok_q, vid_ok_q;
  // Out-of-range addresses are steered to word 0 and their results masked, so the RAM never sees them.
  always_comb begin
    accept = bus.cpu_valid && !bus.cpu_ready && state != FILL;
    cpu_ok = {1'b0, bus.cpu_addr} < LIM;
    fill_ok = {1'b0, ptr} < LIM;
    last = rem == (ADDR_W+1)'(1) || {1'b0, ptr} >= LIM - 1'b1;
    vid_idx = VI'(bus.vid_addr >> VID_SHIFT);
    vid_ok = {1'b0, vid_idx} < VLIM;
    a_addr = state == FILL ? (fill_ok ? AW'(ptr) : '0) : (cpu_ok ? AW'(bus.cpu_addr) : '0);
    a_we = rst ? '0 : state == FILL ? {NB{fill_ok}} : (accept && cpu_ok ? bus.cpu_wstrb : '0);
    a_wdata = state == FILL ? fdata : bus.cpu_wdata;
    b_addr = vid_ok ? AW'(vid_idx) : '0;
  end
  assign bus.cpu_rdata = bus.cpu_ready && cpu_ok_q ? a_q : '0;
  assign bus.vid_rdata = vid_ok_q ? b_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.cpu_ready <= 1'b0;
      bus.fill_busy <= 1'b0;
      bus.fill_done <= 1'b0;
      cpu_ok_q <= 1'b0;
      vid_ok_q <= 1'b0;
    end else begin
      bus.cpu_ready <= accept;
      cpu_ok_q <= cpu_ok;
      vid_ok_q <= vid_ok;
      bus.fill_done <= 1'b0;
      if (state == IDLE && bus.fill_start) begin
        ptr <= bus.fill_base;
        rem <= bus.fill_count;
        fdata <= bus.fill_data;
        state <= bus.fill_count == '0 ? DONE : FILL;
        bus.fill_busy <= bus.fill_count != '0;
        bus.fill_done <= bus.fill_count == '0;
      end else if (state == FILL) begin
        ptr <= ptr + 1'b1;
        rem <= rem - 1'b1;
        if (last) begin
          state <= DONE;
          bus.fill_busy <= 1'b0;
          bus.fill_done <= 1'b1;
        end
      end else if (state == DONE) state <= IDLE;
    end
  end
  gpu_vram_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bank (
    .clk(clk), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata), .a_q(a_q),
    .b_addr(b_addr), .b_q(b_q)
  );
endmodule

// File: tb/tb_gpu_vram_ctl.sv
// tb_gpu_vram_ctl: randomized and directed checks of gpu_vram_ctl against a word-array model.
module tb_gpu_vram_ctl;
  localparam int DEPTH = 1536;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] rd;
  gpu_vram_ctl_if #(.DATA_W(32), .ADDR_W(11), .VID_ADDR_W(13)) bus ();
  gpu_vram_ctl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(11), .VID_ADDR_W(13), .VID_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cpu_txn(input int addr, input logic [3:0] strb, input logic [31:0] wd,
                         input bit chk_rd, input int exp_lat, output logic [31:0] rdata);
    int n = 0;
    logic [31:0] exp = (addr < DEPTH) ? ref_mem[addr] : 32'h0;
    bus.cpu_valid = 1'b1; bus.cpu_addr = 11'(addr); bus.cpu_wstrb = strb; bus.cpu_wdata = wd;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.cpu_ready && n < 200);
    chk("cpu_lat", 32'(n), 32'(exp_lat));
    rdata = bus.cpu_rdata;
    if (chk_rd) chk("cpu_rdata", rdata, exp);
    bus.cpu_valid = 1'b0;
    if (addr < DEPTH)
      for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
    @(posedge clk); #1;
    chk("cpu_ready_pulse", 32'(bus.cpu_ready), 32'h0);
  endtask
  task automatic vid_chk(input string tag, input int a);
    int idx = a >> 2;
    bus.vid_addr = 13'(a);
    @(posedge clk); #1;
    chk(tag, bus.vid_rdata, idx < DEPTH ? ref_mem[idx] : 32'h0);
  endtask
  task automatic range_chk(input string tag, input int lo, input int hi);
    for (int w = lo; w <= hi; w++) if (w >= 0 && w < DEPTH) vid_chk(tag, w << 2);
  endtask
  task automatic do_fill(input string tag, input int base, input int cnt, input logic [31:0] d);
    int n, busy_n = 0, done_n = 0, done_at = -1;
    n = (cnt == 0) ? 0 : (base + cnt > DEPTH ? DEPTH - base : cnt);
    bus.fill_start = 1'b1; bus.fill_base = 11'(base); bus.fill_count = 12'(cnt); bus.fill_data = d;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    for (int k = 0; k < n + 4; k++) begin
      if (k >= 1 && k <= n) chk({tag, "_vid_old"}, bus.vid_rdata, ref_mem[base + k - 1]);
      if (bus.fill_busy) busy_n++;
      if (bus.fill_done) begin done_n++; done_at = k; end
      bus.vid_addr = 13'((base + k) << 2);
      @(posedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(n));
    chk({tag, "_done_pulses"}, 32'(done_n), 32'h1);
    chk({tag, "_done_at"}, 32'(done_at), 32'(n));
    for (int i = 0; i < n; i++) ref_mem[base + i] = d;
    range_chk({tag, "_words"}, base - 1, base + n);
  endtask
  initial begin
    int n, done_n;
    bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_wstrb = '0; bus.cpu_wdata = '0;
    bus.vid_addr = '0; bus.fill_start = 1'b0; bus.fill_base = '0; bus.fill_count = '0; bus.fill_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'h0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_vid_rdata", bus.vid_rdata, 32'h0);
    chk("rst_fill_busy", 32'(bus.fill_busy), 32'h0);
    chk("rst_fill_done", 32'(bus.fill_done), 32'h0);
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) cpu_txn(a, 4'hF, $urandom, 1'b0, 1, rd);
    cpu_txn(5, 4'hF, 32'hDEADBEEF, 1'b1, 1, rd);
    cpu_txn(5, 4'h1, 32'h000000AA, 1'b1, 1, rd);
    cpu_txn(5, 4'h0, 32'h0, 1'b1, 1, rd);
    chk("tp_read5", rd, 32'hDEADBEAA);
    cpu_txn(7, 4'hF, 32'h12345678, 1'b1, 1, rd);
    for (int a = 28; a < 32; a++) vid_chk("tp_vid7", a);
    vid_chk("vid_oob_6144", 6144);
    vid_chk("vid_oob_max", 8191);
    cpu_txn(1536, 4'hF, 32'hCAFEF00D, 1'b1, 1, rd);
    cpu_txn(2047, 4'h0, 32'h0, 1'b1, 1, rd);
    vid_chk("oob_write_no_alias", 0);
    for (int i = 0; i < 300; i++) cpu_txn($urandom_range(0, 2047), 4'($urandom_range(0, 15)), $urandom, 1'b1, 1, rd);
    for (int i = 0; i < 100; i++) vid_chk("vid_rand", $urandom_range(0, 8191));
    do_fill("fill10", 10, 4, 32'h20202020);
    cpu_txn(12, 4'hF, 32'h0BADF00D, 1'b1, 1, rd);
    bus.fill_start = 1'b1; bus.fill_base = 11'd10; bus.fill_count = 12'd4; bus.fill_data = 32'h20202020;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    bus.cpu_valid = 1'b1; bus.cpu_addr = 11'd12; bus.cpu_wstrb = 4'h0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.cpu_ready && n < 50);
    chk("stall_lat", 32'(n), 32'd5);
    chk("stall_rdata", bus.cpu_rdata, 32'h20202020);
    bus.cpu_valid = 1'b0;
    for (int i = 10; i < 14; i++) ref_mem[i] = 32'h20202020;
    repeat (2) @(posedge clk); #1;
    range_chk("stall_words", 9, 14);
    do_fill("fill_clip", 1534, 8, 32'h5A5A5A5A);
    vid_chk("clip_no_wrap", 0);
    do_fill("fill_zero", 50, 0, 32'hFFFFFFFF);
    bus.cpu_valid = 1'b1; bus.cpu_addr = 11'd40; bus.cpu_wstrb = 4'hF; bus.cpu_wdata = 32'h11112222;
    bus.fill_start = 1'b1; bus.fill_base = 11'd40; bus.fill_count = 12'd2; bus.fill_data = 32'h77778888;
    @(posedge clk); #1;
    chk("both_ready", 32'(bus.cpu_ready), 32'h1);
    chk("both_rdata", bus.cpu_rdata, ref_mem[40]);
    bus.cpu_valid = 1'b0; bus.fill_start = 1'b0;
    ref_mem[40] = 32'h77778888; ref_mem[41] = 32'h77778888;
    repeat (4) @(posedge clk); #1;
    range_chk("both_words", 39, 42);
    for (int i = 0; i < 4; i++) do_fill("fill_rand", $urandom_range(0, DEPTH - 1), $urandom_range(0, 40), $urandom);
    bus.fill_start = 1'b1; bus.fill_base = 11'd200; bus.fill_count = 12'd100; bus.fill_data = 32'hA5A5C3C3;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bus.fill_busy), 32'h0);
    chk("abort_ready", 32'(bus.cpu_ready), 32'h0);
    rst = 1'b0;
    done_n = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.fill_done) done_n++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(done_n), 32'h0);
    for (int i = 200; i < 210; i++) ref_mem[i] = 32'hA5A5C3C3;
    range_chk("abort_words", 199, 212);
    range_chk("abort_tail", 298, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
